// File: rtl/serial_pkg.sv
// Shared definitions for the serializer arbiter slice.
// Contents:
//   SER_DATA_WIDTH  default parallel word width, matching the serializer
//   arb_state_t     arbiter FSM state encoding
package serial_pkg;

    localparam int SER_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_SEND  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches req starting at rr_ptr+1 and wrapping, so the source served last
// has the lowest priority on the next pick.
// Ports:
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   IDX_W    index of the most recently served source
//   valid   out  1        at least one request is set
//   idx     out  IDX_W    index of the winning source (0 when valid=0)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter/sequencer that shares one serializer between NUM_REQ
// parallel-word sources. The winning word is captured into ser_data_in,
// held for one LOAD cycle, then ser_start pulses; the arbiter waits for
// ser_busy to fall and pulses done.
//
// Optional feature: define SERIAL_ARB_GAP_EN to insert GAP_CYCLES idle-line
// cycles after each frame. Without it, GAP_CYCLES is unused and SEND returns
// straight to IDLE.
//
// Ports:
//   clock        in   1                   rising-edge clock (shared with serializer)
//   reset_n      in   1                   asynchronous active-low reset
//   req          in   NUM_REQ             per-source request, held until ack
//   req_data     in   NUM_REQ*DATA_WIDTH  source i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          out  NUM_REQ             one-hot pulse: word captured from source i
//   done         out  1                   pulse: frame fully shifted out
//   grant_id     out  $clog2(NUM_REQ)     source of the current/last frame
//   active       out  1                   high from ack through done
//   ser_data_in  out  DATA_WIDTH          serializer data_in
//   ser_start    out  1                   serializer start
//   ser_busy     in   1                   serializer busy
module serializer_arbiter
    import serial_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = SER_DATA_WIDTH,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic [DATA_WIDTH-1:0]         ser_data_in,
    output logic                          ser_start,
    input  logic                          ser_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || GAP_CYCLES < 0) begin : g_bad_params
        $error("serializer_arbiter: NUM_REQ must be >= 2 and GAP_CYCLES >= 0");
    end

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      ack_d;
    logic                    done_d;
    logic                    active_d;
    logic                    start_d;
    logic [IDX_W-1:0]        grant_d;
    logic [DATA_WIDTH-1:0]   data_d;

    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;

`ifdef SERIAL_ARB_GAP_EN
    // Holds remaining gap cycles minus one; zero means this is the last one.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear in the cycle after the transition that
    // produces them (e.g. ser_start is high while state_q == ST_START).
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        ack_d    = '0;
        done_d   = 1'b0;
        active_d = 1'b0;
        start_d  = 1'b0;
        grant_d  = grant_id;
        data_d   = ser_data_in;
`ifdef SERIAL_ARB_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_LOAD;
                    active_d = 1'b1;
                    grant_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IDX_W'(i)) begin
                            ack_d[i] = 1'b1;
                            data_d   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
            ST_LOAD: begin
                state_d  = ST_START;
                start_d  = 1'b1;
                active_d = 1'b1;
            end
            ST_START: begin
                state_d  = ST_SEND;
                active_d = 1'b1;
            end
            ST_SEND: begin
                // Stay active through the done cycle, which follows the exit edge.
                active_d = 1'b1;
                if (!ser_busy) begin
                    done_d = 1'b1;
`ifdef SERIAL_ARB_GAP_EN
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_ARB_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            ack         <= '0;
            done        <= 1'b0;
            active      <= 1'b0;
            ser_start   <= 1'b0;
            grant_id    <= '0;
            ser_data_in <= '0;
`ifdef SERIAL_ARB_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ack         <= ack_d;
            done        <= done_d;
            active      <= active_d;
            ser_start   <= start_d;
            grant_id    <= grant_d;
            ser_data_in <= data_d;
`ifdef SERIAL_ARB_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    a_ack_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(ack));

    a_start_only_in_start: assert property (@(posedge clock) disable iff (!reset_n)
        ser_start |-> (state_q == ST_START));

    // The word may only change on the IDLE->LOAD edge.
    a_data_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q != ST_IDLE) |=> $stable(ser_data_in));

    // A busy serializer while we are about to start a frame is a protocol error.
    a_busy_when_idle: assert property (@(posedge clock) disable iff (!reset_n)
        !(((state_q == ST_IDLE) || (state_q == ST_LOAD)) && ser_busy));

endmodule

// File: tb/tb_serializer_arbiter.sv
module tb_serializer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
`ifdef SERIAL_ARB_GAP_EN
    localparam int GAP     = 2;
`else
    localparam int GAP     = 0;
`endif
    // ack in T+1, done in T+4+DW, next request sampled in the done cycle
    // (or after the gap) -> next ack DW+4+GAP cycles after the previous one.
    localparam int PERIOD  = DW + 4 + GAP;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        done;
    logic [1:0]  grant_id;
    logic        active;
    logic [7:0]  ser_data_in;
    logic        ser_start;
    logic        ser_busy;

    logic        tx;
    logic [7:0]  sh;
    int          scnt;

    logic [7:0]  words [4];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          model_last = NUM_REQ - 1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    serializer_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .GAP_CYCLES (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .grant_id    (grant_id),
        .active      (active),
        .ser_data_in (ser_data_in),
        .ser_start   (ser_start),
        .ser_busy    (ser_busy)
    );

    // Serializer peer: loads on start when idle, busy for DW cycles, LSB first,
    // line idles high. Reset from the same source as the arbiter.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ser_busy <= 1'b0;
            tx       <= 1'b1;
            sh       <= '0;
            scnt     <= 0;
        end else if (!ser_busy) begin
            if (ser_start) begin
                ser_busy <= 1'b1;
                tx       <= ser_data_in[0];
                sh       <= ser_data_in >> 1;
                scnt     <= DW - 1;
            end
        end else if (scnt == 0) begin
            ser_busy <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx   <= sh[0];
            sh   <= sh >> 1;
            scnt <= scnt - 1;
        end
    end

    // Round-robin rule: first set request after the last winner, wrapping.
    function automatic int model_pick(input logic [3:0] r, input int last);
        int i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (last + k) % NUM_REQ;
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        if (i < 0) return 4'b0;
        return 4'b1 << i;
    endfunction

    task automatic skip(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pack_words();
        req_data = {words[3], words[2], words[1], words[0]};
    endtask

    task automatic wait_ack(input int budget, output logic [3:0] seen, output int at_cyc);
        seen   = '0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (ack != 4'b0) begin
                seen   = ack;
                at_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req     = '0;
        skip(2);
        reset_n    = 1'b1;
        model_last = NUM_REQ - 1;
    endtask

    task automatic test_reset();
        int acks;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b want 0", active); end
        checks++; if (ser_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", ser_start); end
        checks++; if (ser_data_in !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", ser_data_in); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        skip(2);
        reset_n    = 1'b1;
        model_last = NUM_REQ - 1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ack != 4'b0 || ser_start) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL idle_no_req: got %0d activity cycles want 0", acks); end
    endtask

    task automatic test_single();
        logic [7:0] got;
        int         exp;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        words[2] = 8'hA5;
        pack_words();
        req = 4'b0100;
        exp = model_pick(req, model_last);
        skip(1);
        checks++; if (ack !== onehot(exp)) begin failures++; $display("FAIL single_ack: got %b want %b", ack, onehot(exp)); end
        checks++; if (ser_data_in !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", ser_data_in); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL single_active_ack: got %b want 1", active); end
        model_last = exp;
        req = '0;
        skip(1);
        checks++; if (ser_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", ser_start); end
        got = '0;
        for (int k = 0; k < DW; k++) begin
            skip(1);
            got[k] = tx;
        end
        checks++; if (got !== 8'hA5) begin failures++; $display("FAIL single_serial: got %b want %b (bit0 first)", got, 8'hA5); end
        skip(1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_early: got %b want 0", done); end
        skip(1);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL single_active_done: got %b want 1", active); end
        skip(1);
        checks++; if ({done, active} !== 2'b00) begin failures++; $display("FAIL single_after: got done=%b active=%b want 0 0", done, active); end
    endtask

    task automatic test_back_to_back();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] seen;
        int         at, prev;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'(i << 6) | 8'($urandom_range(0, 63));
        pack_words();
        req  = 4'b1111;
        prev = -1;
        for (int f = 0; f < 5; f++) begin
            wait_ack(2 * PERIOD, seen, at);
            checks++; if (seen !== onehot(order[f])) begin failures++; $display("FAIL rr_order[%0d]: got %b want %b", f, seen, onehot(order[f])); end
            checks++; if (ser_data_in !== words[order[f]]) begin failures++; $display("FAIL rr_data[%0d]: got %h want %h", f, ser_data_in, words[order[f]]); end
            if (f > 0) begin
                checks++; if (at - prev !== PERIOD) begin failures++; $display("FAIL rr_period[%0d]: got %0d want %0d", f, at - prev, PERIOD); end
            end
            prev = at;
            model_last = order[f];
            words[order[f]] = 8'(order[f] << 6) | 8'($urandom_range(0, 63));
            pack_words();
            skip(DW + 3);
            checks++; if (done !== 1'b1 || grant_id !== 2'(order[f])) begin failures++; $display("FAIL rr_done[%0d]: got done=%b grant=%0d want 1 %0d", f, done, grant_id, order[f]); end
        end
        req = '0;
        skip(PERIOD + 2);
    endtask

    task automatic test_wrap();
        int         order [2] = '{0, 3};
        logic [3:0] seen;
        int         at;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        pack_words();
        req = 4'b1000;
        wait_ack(2 * PERIOD, seen, at);
        checks++; if (seen !== 4'b1000) begin failures++; $display("FAIL wrap_first: got %b want 1000", seen); end
        req = 4'b1001;
        for (int f = 0; f < 2; f++) begin
            wait_ack(2 * PERIOD, seen, at);
            checks++; if (seen !== onehot(order[f])) begin failures++; $display("FAIL wrap_order[%0d]: got %b want %b", f, seen, onehot(order[f])); end
            req = req & ~onehot(order[f]);
        end
        model_last = 3;
        skip(PERIOD + 2);
    endtask

    task automatic test_reset_mid_send();
        logic [3:0] seen;
        int         at, dones, exp;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom) | 8'h01;
        pack_words();
        req = 4'b0100;
        wait_ack(2 * PERIOD, seen, at);
        checks++; if (seen !== 4'b0100) begin failures++; $display("FAIL mid_ack: got %b want 0100", seen); end
        req = '0;
        skip(5);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({ack, done, active, ser_start, ser_data_in, grant_id} !== 17'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got ack=%b done=%b active=%b start=%b data=%h grant=%0d want all 0",
                     ack, done, active, ser_start, ser_data_in, grant_id);
        end
        @(negedge clock);
        reset_n    = 1'b1;
        model_last = NUM_REQ - 1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", dones); end
        req = 4'b0010;
        exp = model_pick(req, model_last);
        wait_ack(2, seen, at);
        checks++; if (seen !== onehot(exp)) begin failures++; $display("FAIL mid_next_ack: got %b want %b", seen, onehot(exp)); end
        checks++; if (ser_data_in !== words[exp]) begin failures++; $display("FAIL mid_next_data: got %h want %h", ser_data_in, words[exp]); end
        model_last = exp;
        req = '0;
        skip(PERIOD + 2);
    endtask

    task automatic test_pulse_in_send();
        logic [3:0] seen;
        int         at, acked1;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        pack_words();
        req = 4'b0001;
        wait_ack(2 * PERIOD, seen, at);
        checks++; if (seen !== 4'b0001) begin failures++; $display("FAIL pulse_first: got %b want 0001", seen); end
        req = '0;
        skip(4);
        req = 4'b0010;
        skip(1);
        req = '0;
        acked1 = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clock);
            if (ack[1]) acked1++;
        end
        checks++; if (acked1 !== 0) begin failures++; $display("FAIL pulse_ignored: got %0d acks want 0", acked1); end
        model_last = 0;
    endtask

    task automatic test_random();
        logic [3:0] pending, seen;
        int         at, exp;
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
        pack_words();
        pending = 4'($urandom_range(1, 15));
        req = pending;
        for (int n = 0; n < 24; n++) begin
            exp = model_pick(pending, model_last);
            wait_ack(2 * PERIOD, seen, at);
            checks++; if (seen !== onehot(exp)) begin failures++; $display("FAIL rand_ack[%0d]: got %b want %b (req %b)", n, seen, onehot(exp), pending); end
            checks++; if (exp >= 0 && ser_data_in !== words[exp]) begin failures++; $display("FAIL rand_data[%0d]: got %h want %h", n, ser_data_in, words[exp]); end
            if (exp >= 0) begin
                model_last = exp;
                pending[exp] = 1'b0;
                words[exp] = 8'($urandom);
            end
            pending = pending | 4'($urandom_range(0, 15));
            if (pending == 4'b0) pending = 4'($urandom_range(1, 15));
            pack_words();
            req = pending;
            skip(DW + 3);
            checks++; if (done !== 1'b1 || grant_id !== 2'(exp)) begin failures++; $display("FAIL rand_done[%0d]: got done=%b grant=%0d want 1 %0d", n, done, grant_id, exp); end
        end
        req = '0;
        skip(PERIOD + 2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_reset_mid_send();
        test_pulse_in_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
